// File: rtl/tmr_group_arbiter.sv
// Lock-aware round-robin arbiter. In redundancy mode it holds the grant on one
// pipeline until all Copies beats of an item have passed. A stalled lock is released after LockTimeout cycles.
module tmr_group_arbiter #(
  parameter int unsigned NumIn       = 3,
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned Copies      = 3,
  parameter int unsigned LockTimeout = 5,
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic [NumIn-1:0]                  req_i,
  output logic [NumIn-1:0]                  gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
  output logic                              req_o,
  input  logic                              gnt_i,
  output logic [DataWidth-1:0]              data_o,
  output logic [IdxWidth-1:0]               idx_o,
  output logic                              locked_o,
  output logic                              timeout_o
);

  localparam int unsigned CntWidth = $clog2(Copies + 1);
  localparam int unsigned ToWidth  = $clog2(LockTimeout + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [IdxWidth-1:0]   owner_q, owner_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ToWidth-1:0]    to_q, to_d;
  logic                  timeout_q, timeout_d;

  logic [IdxWidth-1:0]   win_idx;
  logic                  win_valid;
  logic [IdxWidth-1:0]   sel_idx;
  logic                  sel_req;
  logic                  hs;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
    if (32'(i) == NumIn - 1) return '0;
    return i + IdxWidth'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
    end
  end

  // First requester at or above the round-robin pointer, wrapping modulo NumIn.
  always_comb begin
    int unsigned j;
    j         = 0;
    win_valid = 1'b0;
    win_idx   = rr_q;
    for (int unsigned k = 0; k < NumIn; k++) begin
      j = 32'(rr_q) + k;
      if (j >= NumIn) j = j - NumIn;
      if (!win_valid && req_i[IdxWidth'(j)]) begin
        win_valid = 1'b1;
        win_idx   = IdxWidth'(j);
      end
    end
  end

  always_comb begin
    if (state_q == LOCKED) begin
      sel_idx = owner_q;
      sel_req = req_i[owner_q];
    end else begin
      sel_idx = win_idx;
      sel_req = win_valid;
    end
    hs = sel_req & gnt_i;
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (enable_i && (Copies > 1)) begin
            state_d = LOCKED;
            owner_d = win_idx;
            cnt_d   = CntWidth'(1);
            to_d    = '0;
          end else begin
            rr_d = next_idx(win_idx);
          end
        end
      end
      LOCKED: begin
        // Dropping enable ends the group early but still honours this cycle's beat.
        if (!enable_i || (hs && (cnt_q == CntWidth'(Copies - 1)))) begin
          state_d = IDLE;
          rr_d    = next_idx(owner_q);
          cnt_d   = '0;
          to_d    = '0;
        end else if (hs) begin
          cnt_d = cnt_q + CntWidth'(1);
          to_d  = '0;
        end else if (to_q == ToWidth'(LockTimeout - 1)) begin
          state_d   = IDLE;
          rr_d      = next_idx(owner_q);
          cnt_d     = '0;
          to_d      = '0;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + ToWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = '0;
    req_o     = 1'b0;
    idx_o     = '0;
    data_o    = '0;
    locked_o  = (state_q == LOCKED);
    timeout_o = timeout_q;
    if (!rst_i) begin
      req_o  = sel_req;
      idx_o  = sel_idx;
      data_o = data_i[sel_idx];
      if (hs) gnt_o[sel_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_tmr_group_arbiter.sv
// Self-checking bench for tmr_group_arbiter: directed vector table, hand-written
// lock corner cases, then randomized traffic against a behavioural model.
module tb_tmr_group_arbiter;

  localparam int NumIn       = 3;
  localparam int DataWidth   = 8;
  localparam int Copies      = 3;
  localparam int LockTimeout = 5;
  localparam int IdxWidth    = 2;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            en;
  logic [NumIn-1:0]                req;
  logic [NumIn-1:0]                gnt_o;
  logic [NumIn-1:0][DataWidth-1:0] data;
  logic                            req_o;
  logic                            gnt;
  logic [DataWidth-1:0]            data_o;
  logic [IdxWidth-1:0]             idx_o;
  logic                            locked_o;
  logic                            timeout_o;

  int compared   = 0;
  int mismatched = 0;

  // Model: lock flag, owner, beats still owed, and patience left before forced release.
  bit                   mLocked;
  int                   mOwner;
  int                   mLeft;
  int                   mPatience;
  int                   mRr;
  bit                   mTimeout;
  bit                   eReq;
  logic [NumIn-1:0]     eGnt;
  int                   eIdx;
  logic [DataWidth-1:0] eData;

  typedef struct {
    bit                   rst;
    bit                   en;
    logic [NumIn-1:0]     req;
    bit                   gnt;
    bit                   expReq;
    logic [NumIn-1:0]     expGnt;
    int                   expIdx;
    logic [DataWidth-1:0] expData;
    bit                   expLocked;
    bit                   expTimeout;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  tmr_group_arbiter #(
    .NumIn(NumIn), .DataWidth(DataWidth), .Copies(Copies), .LockTimeout(LockTimeout)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .req_i(req), .gnt_o(gnt_o),
    .data_i(data), .req_o(req_o), .gnt_i(gnt), .data_o(data_o), .idx_o(idx_o),
    .locked_o(locked_o), .timeout_o(timeout_o)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelPredict();
    bit found;
    found = 1'b0;
    eReq  = 1'b0;
    eGnt  = '0;
    eIdx  = 0;
    eData = '0;
    if (!rst) begin
      if (mLocked) begin
        eIdx = mOwner;
        eReq = req[mOwner];
      end else begin
        eIdx = mRr;
        for (int k = 0; k < NumIn; k++) begin
          int j;
          j = (mRr + k) % NumIn;
          if (!found && req[j]) begin
            found = 1'b1;
            eIdx  = j;
          end
        end
        eReq = found;
      end
      eData = data[eIdx];
      if (eReq && gnt) eGnt[eIdx] = 1'b1;
    end
  endtask

  task automatic modelAdvance();
    bit hs;
    hs = eReq && gnt;
    if (rst) begin
      mLocked   = 1'b0;
      mOwner    = 0;
      mLeft     = 0;
      mPatience = LockTimeout;
      mRr       = 0;
      mTimeout  = 1'b0;
    end else begin
      mTimeout = 1'b0;
      if (!mLocked) begin
        if (hs) begin
          if (en && Copies > 1) begin
            mLocked   = 1'b1;
            mOwner    = eIdx;
            mLeft     = Copies - 1;
            mPatience = LockTimeout;
          end else begin
            mRr = (eIdx + 1) % NumIn;
          end
        end
      end else begin
        if (hs) begin
          mLeft--;
          mPatience = LockTimeout;
        end else begin
          mPatience--;
        end
        if (!en || mLeft == 0) begin
          mLocked = 1'b0;
          mRr     = (mOwner + 1) % NumIn;
        end else if (mPatience == 0) begin
          mLocked  = 1'b0;
          mRr      = (mOwner + 1) % NumIn;
          mTimeout = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [NumIn-1:0] q, input bit g);
    rst = r;
    en  = e;
    req = q;
    gnt = g;
    #3;
    modelPredict();
  endtask

  task automatic tick();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic checkAgainstModel();
    checkOutput("rand_req_o", 32'(req_o), 32'(eReq));
    checkOutput("rand_gnt_o", 32'(gnt_o), 32'(eGnt));
    checkOutput("rand_idx_o", 32'(idx_o), eIdx);
    checkOutput("rand_data_o", 32'(data_o), 32'(eData));
    checkOutput("rand_locked_o", 32'(locked_o), 32'(mLocked));
    checkOutput("rand_timeout_o", 32'(timeout_o), 32'(mTimeout));
  endtask

  function automatic vec_t row(bit r, bit e, logic [NumIn-1:0] q, bit g, bit xReq,
                               logic [NumIn-1:0] xGnt, int xIdx, logic [DataWidth-1:0] xData,
                               bit xLocked, bit xTo);
    vec_t v;
    v = '{rst: r, en: e, req: q, gnt: g, expReq: xReq, expGnt: xGnt, expIdx: xIdx,
          expData: xData, expLocked: xLocked, expTimeout: xTo};
    return v;
  endfunction

  initial begin
    data = {8'hA2, 8'hA1, 8'hA0};
    applyStimulus(1, 0, '0, 0);
    tick();

    // Reset, then one full round of locked groups, then plain per-beat rotation.
    vecs.push_back(row(1, 1, 3'b111, 1, 0, 3'b000, 0, 8'h00, 0, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b001, 0, 8'hA0, 0, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b001, 0, 8'hA0, 1, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b001, 0, 8'hA0, 1, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b010, 1, 8'hA1, 0, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b010, 1, 8'hA1, 1, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b010, 1, 8'hA1, 1, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b100, 2, 8'hA2, 0, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b100, 2, 8'hA2, 1, 0));
    vecs.push_back(row(0, 1, 3'b111, 1, 1, 3'b100, 2, 8'hA2, 1, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(row(0, 0, 3'b111, 1, 1, 3'(1 << (k % 3)), k % 3, 8'hA0 + 8'(k % 3), 0, 0));
    vecs.push_back(row(0, 1, 3'b000, 1, 0, 3'b000, 0, 8'hA0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].gnt);
      checkOutput("vec_req_o", 32'(req_o), 32'(vecs[i].expReq));
      checkOutput("vec_gnt_o", 32'(gnt_o), 32'(vecs[i].expGnt));
      checkOutput("vec_idx_o", 32'(idx_o), vecs[i].expIdx);
      checkOutput("vec_data_o", 32'(data_o), 32'(vecs[i].expData));
      checkOutput("vec_locked_o", 32'(locked_o), 32'(vecs[i].expLocked));
      checkOutput("vec_timeout_o", 32'(timeout_o), 32'(vecs[i].expTimeout));
      tick();
    end

    // Owner 1 locked, then goes quiet while others request: masked, then timed out.
    applyStimulus(1, 1, 3'b000, 0);
    tick();
    applyStimulus(0, 1, 3'b010, 1);
    checkOutput("mask_first_idx", 32'(idx_o), 1);
    tick();
    for (int c = 0; c < LockTimeout; c++) begin
      applyStimulus(0, 1, 3'b101, 1);
      checkOutput("mask_req_o", 32'(req_o), 0);
      checkOutput("mask_gnt_o", 32'(gnt_o), 0);
      checkOutput("mask_locked_o", 32'(locked_o), 1);
      checkOutput("mask_early_timeout", 32'(timeout_o), 0);
      tick();
    end
    applyStimulus(0, 1, 3'b101, 1);
    checkOutput("mask_timeout_o", 32'(timeout_o), 1);
    checkOutput("mask_unlocked", 32'(locked_o), 0);
    checkOutput("mask_next_idx", 32'(idx_o), 2);
    tick();
    applyStimulus(0, 1, 3'b000, 0);
    checkOutput("mask_pulse_once", 32'(timeout_o), 0);
    checkOutput("mask_relock", 32'(locked_o), 1);
    tick();

    // A handshake on the cycle the timeout would fire wins and clears the idle count.
    applyStimulus(1, 1, 3'b000, 0);
    tick();
    applyStimulus(0, 1, 3'b001, 1);
    tick();
    for (int c = 0; c < LockTimeout - 1; c++) begin
      applyStimulus(0, 1, 3'b000, 1);
      checkOutput("edge_locked_o", 32'(locked_o), 1);
      tick();
    end
    applyStimulus(0, 1, 3'b001, 1);
    checkOutput("edge_hs_gnt_o", 32'(gnt_o), 32'b001);
    tick();
    for (int c = 0; c < LockTimeout - 1; c++) begin
      applyStimulus(0, 1, 3'b000, 1);
      checkOutput("edge_no_timeout", 32'(timeout_o), 0);
      checkOutput("edge_still_locked", 32'(locked_o), 1);
      tick();
    end
    applyStimulus(0, 1, 3'b001, 1);
    checkOutput("edge_final_gnt_o", 32'(gnt_o), 32'b001);
    tick();
    applyStimulus(0, 1, 3'b000, 0);
    checkOutput("edge_group_done", 32'(locked_o), 0);
    checkOutput("edge_done_timeout", 32'(timeout_o), 0);
    tick();

    // Backpressure mid-group holds data and lock until the consumer is ready again.
    data[0] = 8'h55;
    applyStimulus(1, 1, 3'b000, 0);
    tick();
    applyStimulus(0, 1, 3'b001, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, 3'b001, 0);
      checkOutput("bp_data_o", 32'(data_o), 32'h55);
      checkOutput("bp_gnt_o", 32'(gnt_o), 0);
      checkOutput("bp_req_o", 32'(req_o), 1);
      checkOutput("bp_locked_o", 32'(locked_o), 1);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 1, 3'b001, 1);
      checkOutput("bp_resume_gnt_o", 32'(gnt_o), 32'b001);
      checkOutput("bp_resume_locked", 32'(locked_o), 1);
      tick();
    end
    applyStimulus(0, 1, 3'b000, 0);
    checkOutput("bp_group_done", 32'(locked_o), 0);
    tick();
    data[0] = 8'hA0;

    // Reset in the middle of a group discards it without a timeout pulse.
    applyStimulus(1, 1, 3'b000, 0);
    tick();
    applyStimulus(0, 1, 3'b010, 1);
    tick();
    applyStimulus(0, 1, 3'b010, 1);
    tick();
    applyStimulus(1, 1, 3'b111, 1);
    checkOutput("rst_req_o", 32'(req_o), 0);
    checkOutput("rst_gnt_o", 32'(gnt_o), 0);
    checkOutput("rst_idx_o", 32'(idx_o), 0);
    checkOutput("rst_data_o", 32'(data_o), 0);
    tick();
    applyStimulus(0, 1, 3'b111, 0);
    checkOutput("rst_locked_o", 32'(locked_o), 0);
    checkOutput("rst_timeout_o", 32'(timeout_o), 0);
    checkOutput("rst_winner", 32'(idx_o), 0);
    tick();

    // Random traffic, with stretches of heavy backpressure to provoke timeouts.
    applyStimulus(1, 1, 3'b000, 0);
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, e, g;
      logic [NumIn-1:0] q;
      for (int i = 0; i < NumIn; i++) data[i] = 8'($urandom);
      r = ($urandom % 64) == 0;
      e = ($urandom % 8) != 0;
      q = 3'($urandom);
      if (((cyc / 16) % 3) == 2) g = ($urandom % 8) == 0;
      else g = ($urandom % 4) != 0;
      applyStimulus(r, e, q, g);
      checkAgainstModel();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
